// File: rtl/handshake_responder.sv
// Slave end of a valid/ready request handshake: captures one request, holds it
// for a programmable delay, then returns the payload on a response channel.
module handshake_responder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LAT_W-1:0]  lat_cfg,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      txn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    txn_cnt_d = txn_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          cnt_d   = lat_cfg;
          state_d = (lat_cfg != '0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d   = ST_IDLE;
          txn_cnt_d = txn_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode straight from registers; no input-to-output paths.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = data_q;
  assign busy       = (state_q != ST_IDLE);
  assign txn_cnt    = txn_cnt_q;

endmodule
